blur_scale_sequencer: RTL and testbench
=======================================

Name: blur_scale_sequencer

Overview:
Frame-level controller for the Gaussian blur engine. Runs up to four blur scale passes in order (3x3, 5x5_0, 5x5_1, 7x7), one start/done handshake per pass, and selects which blur SRAM bank the engine writes. Arbitrates the single image-SRAM address port between the blur engine and a host loader. Includes a per-pass watchdog.

Parameters:
ADDR_W, 9, image/blur SRAM row-address width
LAST_ROW, 480, final row address; passed through only, for bench checks
GAP_CYCLES, 2, idle cycles after each blur_done before the next pass
TIMEOUT_CYCLES, 8192, maximum cycles a pass may stay in RUN
TO_W, 14, watchdog counter width; must satisfy 2**TO_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle request to process a frame
num_scales  in  3  passes to run, 1..4; latched on accepted frame_start; 0 or >4 saturates to 4
frame_busy  out  1  high from accepted start until done/error
frame_done  out  1  one-cycle pulse after the last pass completes
frame_err  out  1  sticky watchdog error; cleared by the next accepted frame_start
blur_start  out  1  one-cycle start pulse to the blur engine
blur_done  in  1  engine done level; only its rising edge is used
blur_sel  out  2  active scale/bank index (0..3)
blur_img_addr  in  ADDR_W  engine's image-SRAM address
host_req  in  1  host loader requests the image-SRAM port
host_addr  in  ADDR_W  host address
host_gnt  out  1  host owns the port
img_addr  out  ADDR_W  muxed image-SRAM address

Behaviour:
Reset values (asynchronous, active-high reset):
- All outputs 0; state IDLE; scale counter 0; done-edge register 0; watchdog counter 0.
- Reset mid-frame aborts immediately. No frame_done pulse is generated.

States: IDLE, ARM, RUN, GAP, FIN, ERR.

IDLE:
- host_gnt = host_req (combinational) unless a frame is pending.
- A frame_start that arrives while host_gnt=1 sets a pending flag. The frame is accepted in the first cycle with host_req=0.
- frame_start and host_req rising in the same cycle, with host_gnt=0: the frame wins and host_gnt stays 0.
- On accept: latch num_scales (saturated), scale counter := 0, frame_err := 0, next state ARM.

ARM:
- blur_start = 1 for exactly this cycle; blur_sel = scale counter.
- Next state RUN; watchdog := 0.

RUN:
- Watchdog increments each cycle.
- Rising edge of blur_done (current & ~registered previous) -> GAP, with gap counter := 0.
- Watchdog reaching TIMEOUT_CYCLES-1 without a done edge -> ERR.
- A done edge and a timeout in the same cycle: the done edge wins.

GAP:
- Count GAP_CYCLES cycles, then:
  - if scale counter == latched count-1 -> FIN;
  - else scale counter += 1 and go to ARM.

FIN:
- frame_done = 1 for one cycle; next state IDLE.

ERR:
- Set frame_err; next state IDLE. No frame_done.

Outputs and ignored inputs:
- frame_busy = (state != IDLE).
- blur_sel holds its value in RUN/GAP and returns to 0 in IDLE.
- img_addr = host_gnt ? host_addr : blur_img_addr, combinational. host_gnt is always 0 while frame_busy.
- frame_start while busy is ignored and not queued.
- A blur_done edge outside RUN is ignored; the edge register still tracks.

Latency:
- Accepted frame_start to blur_start: 1 cycle.
- blur_done edge to next blur_start: GAP_CYCLES+1 cycles.

Decomposition:
Shared package blur_pkg holds:
- the state encoding enum;
- scale index constants SC_3X3=0, SC_5X5_0=1, SC_5X5_1=2, SC_7X7=3;
- NUM_SCALES_MAX=4;
- ADDR_W / LAST_ROW defaults, shared with the blur engine.

One natural sub-module, img_port_arb: the host/engine address mux plus the grant and pending-frame logic. The FSM stays in the top level.

Test Plan:
- frame_start with num_scales=4; bench engine raises blur_done 100 cycles after each start -> blur_sel steps 0,1,2,3; exactly 4 blur_start pulses, each 3 cycles after the previous done edge; frame_done pulses once; frame_busy drops the cycle after.
- num_scales=0 and num_scales=7 -> each runs 4 passes; num_scales=1 -> single pass with blur_sel=0, then frame_done.
- host_req held high while frame_start pulses -> host_gnt stays 1 and img_addr=host_addr; drop host_req -> blur_start occurs 1 cycle later (pending honoured).
- TIMEOUT_CYCLES=16; engine never raises done -> frame_err=1 and state returns to IDLE after 16 RUN cycles; no frame_done; next frame_start clears frame_err.
- blur_done held high across GAP and ARM, and the same-cycle done/timeout edge case -> only rising edges advance passes; done takes priority over timeout.
- Assert rst during pass 2 -> all outputs 0 immediately; a subsequent frame_start restarts at blur_sel=0.

Source files
------------

// File: rtl/blur_scale_sequencer_pkg.sv
// Shared definitions for the blur scale sequencer and the blur engine.
package blur_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_GAP,
    S_FIN,
    S_ERR
  } blur_state_t;

  // Scale / blur-bank indices in pass order.
  localparam logic [1:0] SC_3X3   = 2'd0;
  localparam logic [1:0] SC_5X5_0 = 2'd1;
  localparam logic [1:0] SC_5X5_1 = 2'd2;
  localparam logic [1:0] SC_7X7   = 2'd3;

  localparam int NUM_SCALES_MAX = 4;

  // Geometry defaults shared with the blur engine.
  localparam int BLUR_ADDR_W   = 9;
  localparam int BLUR_LAST_ROW = 480;

  // Index of the final pass for a requested pass count; 0 or >4 runs all four.
  function automatic logic [1:0] last_scale_idx(input logic [2:0] n);
    if (n == 3'd0 || n > 3'(NUM_SCALES_MAX)) begin
      return SC_7X7;
    end
    return 2'(n - 3'd1);
  endfunction

endpackage

// File: rtl/blur_scale_sequencer_img_port_arb.sv
// Image-SRAM address port arbiter: host loader vs. blur engine, plus the
// pending-frame logic that lets a host transfer finish before a frame starts.
module img_port_arb
  import blur_pkg::*;
#(
  parameter int ADDR_W = BLUR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idle,
  input  logic              frame_start,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [ADDR_W-1:0] blur_img_addr,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] img_addr,
  output logic              accept
);

  logic pending;
  logic gnt_q;
  logic host_hold;

  // A host already holding the port keeps it; a new request loses to a frame
  // start arriving in the same cycle. Frames are accepted only while idle.
  always_comb begin
    host_hold = gnt_q && host_req;
    accept    = idle && (frame_start || pending) && !host_hold;
    host_gnt  = idle && host_req && !accept;
    img_addr  = host_gnt ? host_addr : blur_img_addr;
  end

  // Remember a frame request that arrived while the host owned the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (!idle || accept) begin
      pending <= 1'b0;
    end else if (frame_start) begin
      pending <= 1'b1;
    end
  end

  // Previous-cycle grant distinguishes a held grant from a fresh request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q <= 1'b0;
    end else begin
      gnt_q <= host_gnt;
    end
  end

endmodule

// File: rtl/blur_scale_sequencer.sv
// Frame-level controller for the Gaussian blur engine: runs up to four blur
// scale passes with a start/done handshake each, selects the blur bank,
// shares the image-SRAM port with the host loader and guards each pass with
// a watchdog.
module blur_scale_sequencer
  import blur_pkg::*;
#(
  parameter int ADDR_W         = BLUR_ADDR_W,
  parameter int LAST_ROW       = BLUR_LAST_ROW,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 8192,
  parameter int TO_W           = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [2:0]        num_scales,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic              blur_start,
  input  logic              blur_done,
  output logic [1:0]        blur_sel,
  input  logic [ADDR_W-1:0] blur_img_addr,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] img_addr
);

  // GAP always lasts at least one cycle, even with GAP_CYCLES of 0.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Catch a final row that does not fit the row address.
  if (LAST_ROW >= (1 << ADDR_W)) begin : g_last_row_check
    $error("LAST_ROW does not fit in ADDR_W bits");
  end

  blur_state_t      state, state_d;
  logic [1:0]       scale_cnt, scale_d;
  logic [1:0]       last_idx, last_d;
  logic [1:0]       pend_last, pend_d;
  logic [TO_W-1:0]  wd_cnt, wd_d;
  logic [GAP_W-1:0] gap_cnt, gap_d;
  logic             err_d;
  logic             done_q;
  logic             done_edge;
  logic             idle;
  logic             accept;

  assign idle      = (state == S_IDLE);
  assign done_edge = blur_done && !done_q;

  img_port_arb #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .idle         (idle),
    .frame_start  (frame_start),
    .host_req     (host_req),
    .host_addr    (host_addr),
    .blur_img_addr(blur_img_addr),
    .host_gnt     (host_gnt),
    .img_addr     (img_addr),
    .accept       (accept)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      scale_cnt <= '0;
      last_idx  <= '0;
      pend_last <= '0;
      wd_cnt    <= '0;
      gap_cnt   <= '0;
      frame_err <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      scale_cnt <= scale_d;
      last_idx  <= last_d;
      pend_last <= pend_d;
      wd_cnt    <= wd_d;
      gap_cnt   <= gap_d;
      frame_err <= err_d;
      done_q    <= blur_done;
    end
  end

  // Next-state and next-datapath logic for the pass sequencer.
  always_comb begin
    state_d = state;
    scale_d = scale_cnt;
    last_d  = last_idx;
    pend_d  = pend_last;
    wd_d    = wd_cnt;
    gap_d   = gap_cnt;
    err_d   = frame_err;

    unique case (state)
      S_IDLE: begin
        // A deferred frame uses the pass count captured with its request.
        if (frame_start) begin
          pend_d = last_scale_idx(num_scales);
        end
        if (accept) begin
          last_d  = frame_start ? last_scale_idx(num_scales) : pend_last;
          scale_d = SC_3X3;
          err_d   = 1'b0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_cnt + TO_W'(1);
        if (done_edge) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else if (wd_cnt == TO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_GAP: begin
        gap_d = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_LAST) begin
          if (scale_cnt == last_idx) begin
            state_d = S_FIN;
          end else begin
            scale_d = scale_cnt + 2'd1;
            state_d = S_ARM;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    frame_busy = !idle;
    blur_start = (state == S_ARM);
    frame_done = (state == S_FIN);
    blur_sel   = idle ? SC_3X3 : scale_cnt;
  end

endmodule

// File: tb/tb_blur_scale_sequencer.sv
// Self-checking bench for blur_scale_sequencer with a short watchdog.
module tb_blur_scale_sequencer;

  localparam int AW  = 9;
  localparam int TO  = 16;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [2:0]    num_scales;
  logic          frame_busy;
  logic          frame_done;
  logic          frame_err;
  logic          blur_start;
  logic          blur_done;
  logic [1:0]    blur_sel;
  logic [AW-1:0] blur_img_addr;
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic          host_gnt;
  logic [AW-1:0] img_addr;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blur_scale_sequencer #(
    .ADDR_W        (AW),
    .LAST_ROW      (480),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TO),
    .TO_W          (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .num_scales   (num_scales),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .blur_start   (blur_start),
    .blur_done    (blur_done),
    .blur_sel     (blur_sel),
    .blur_img_addr(blur_img_addr),
    .host_req     (host_req),
    .host_addr    (host_addr),
    .host_gnt     (host_gnt),
    .img_addr     (img_addr)
  );

  // One frame against an engine that raises done dly[i] cycles after each
  // start (0 = never) and holds it for 'hold' cycles. Expected timing comes
  // from the latency rules: start 1 cycle after accept, next start GAP+1
  // after a done edge, error TO RUN cycles after a start.
  task automatic run_frame(input string nm, input logic [2:0] ns,
                           input int d0, input int d1, input int d2, input int d3,
                           input int hold, input bit poke);
    int dly[4];
    int exp_st[$];
    int got_st[$];
    int got_sel[$];
    int got_done[$];
    int exp_n, acc, a, e, exp_done, exp_fall, exp_err_at;
    int pass, edge_at, drop_at, busy_fall, err_at, sel_idle, c;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    exp_n = (ns == 3'd0 || ns > 3'd4) ? 4 : int'(ns);

    @(negedge clk);
    frame_start = 1'b1;
    num_scales  = ns;
    acc = cyc;

    a = acc + 1; exp_done = -1; exp_fall = -1; exp_err_at = -1;
    for (int i = 0; i < exp_n; i++) begin
      exp_st.push_back(a);
      if (dly[i] <= 0 || dly[i] > TO) begin
        exp_err_at = a + TO + 2;
        exp_fall   = a + TO + 2;
        break;
      end
      e = a + dly[i];
      if (i == exp_n - 1) begin
        exp_done = e + GAP + 1;
        exp_fall = e + GAP + 2;
      end else begin
        a = e + GAP + 1;
      end
    end

    pass = 0; edge_at = -1; drop_at = -1; busy_fall = -1; err_at = -1; sel_idle = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      frame_start = 1'b0;
      num_scales  = 3'($urandom);
      c = cyc;
      if (blur_start) begin
        got_st.push_back(c);
        got_sel.push_back(int'(blur_sel));
        if (pass < 4 && dly[pass] > 0) edge_at = c + dly[pass];
        pass++;
      end
      if (frame_done) got_done.push_back(c);
      if (frame_err && err_at < 0) err_at = c;
      if (busy_fall < 0 && !frame_busy) begin
        busy_fall = c;
        sel_idle  = int'(blur_sel);
      end
      if (poke && c == acc + 2) begin
        frame_start = 1'b1;
        num_scales  = 3'd1;
      end
      if (c == drop_at) blur_done = 1'b0;
      if (c == edge_at) begin
        blur_done = 1'b1;
        drop_at   = c + hold;
      end
      if (busy_fall >= 0 && c >= busy_fall + 6) break;
    end
    blur_done = 1'b0;

    checks++;
    if (got_st.size() !== exp_st.size()) begin
      errors++;
      $display("FAIL %s start_count: got %0d expected %0d", nm, got_st.size(), exp_st.size());
    end
    for (int i = 0; i < exp_st.size() && i < got_st.size(); i++) begin
      checks++;
      if (got_st[i] !== exp_st[i]) begin
        errors++;
        $display("FAIL %s start_cycle[%0d]: got %0d expected %0d", nm, i, got_st[i] - acc, exp_st[i] - acc);
      end
      checks++;
      if (got_sel[i] !== i) begin
        errors++;
        $display("FAIL %s blur_sel[%0d]: got %0d expected %0d", nm, i, got_sel[i], i);
      end
    end
    checks++;
    if (got_done.size() !== ((exp_done >= 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected %0d", nm, got_done.size(), (exp_done >= 0) ? 1 : 0);
    end else if (exp_done >= 0) begin
      checks++;
      if (got_done[0] !== exp_done) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d expected %0d", nm, got_done[0] - acc, exp_done - acc);
      end
    end
    checks++;
    if (busy_fall !== exp_fall) begin
      errors++;
      $display("FAIL %s busy_fall: got %0d expected %0d (-1 = never within budget)", nm,
               (busy_fall < 0) ? -1 : busy_fall - acc, exp_fall - acc);
    end
    checks++;
    if (err_at !== exp_err_at) begin
      errors++;
      $display("FAIL %s frame_err_cycle: got %0d expected %0d (-1 = never)", nm,
               (err_at < 0) ? -1 : err_at - acc, (exp_err_at < 0) ? -1 : exp_err_at - acc);
    end
    checks++;
    if (sel_idle !== 0) begin
      errors++;
      $display("FAIL %s idle_blur_sel: got %0d expected 0", nm, sel_idle);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    blur_img_addr = AW'($urandom);
    repeat (2) @(negedge clk);
    checks++;
    if ({frame_busy, frame_done, frame_err, blur_start, blur_sel, host_gnt} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {frame_busy, frame_done, frame_err, blur_start, blur_sel, host_gnt});
    end
    checks++;
    if (img_addr !== blur_img_addr) begin
      errors++;
      $display("FAIL reset_img_addr: got %h expected %h", img_addr, blur_img_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({frame_busy, frame_done, frame_err, blur_start, blur_sel, host_gnt} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 000000",
               {frame_busy, frame_done, frame_err, blur_start, blur_sel, host_gnt});
    end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 2; i++) begin
      run_frame("full4", 3'd4, $urandom_range(TO, 1), $urandom_range(TO, 1),
                $urandom_range(TO, 1), $urandom_range(TO, 1), 2, 1'b0);
    end
  endtask

  task automatic test_saturation();
    run_frame("ns0", 3'd0, 7, 3, 12, 1, 1, 1'b0);
    run_frame("ns7", 3'd7, 2, 16, 5, 9, 2, 1'b0);
    run_frame("ns1", 3'd1, 6, 0, 0, 0, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_frame("nsrand", 3'($urandom_range(7, 0)), $urandom_range(TO, 1), $urandom_range(TO, 1),
                $urandom_range(TO, 1), $urandom_range(TO, 1), 1, 1'b0);
    end
  endtask

  task automatic test_busy_ignore();
    run_frame("busy_start", 3'd2, 8, 4, 0, 0, 2, 1'b1);
  endtask

  task automatic test_done_level();
    run_frame("done_held", 3'd4, 3, 3, $urandom_range(TO, 3), 16, 5, 1'b0);
    run_frame("done_tie", 3'd3, TO, TO, TO, 0, 2, 1'b0);
  endtask

  task automatic test_timeout();
    run_frame("timeout", 3'd4, 5, 0, 0, 0, 1, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", frame_err);
    end
    run_frame("after_timeout", 3'd2, 4, 9, 0, 0, 2, 1'b0);
  endtask

  task automatic test_host();
    logic [AW-1:0] ha, ba;
    int waited;
    ha = AW'($urandom);
    ba = AW'($urandom);
    if (ha == ba) ha = ~ba;
    @(negedge clk);
    host_req = 1'b1; host_addr = ha; blur_img_addr = ba;
    #1;
    checks++;
    if (host_gnt !== 1'b1 || img_addr !== ha) begin
      errors++;
      $display("FAIL host_grant: got gnt=%b addr=%h expected gnt=1 addr=%h", host_gnt, img_addr, ha);
    end
    @(negedge clk);
    frame_start = 1'b1; num_scales = 3'd1;
    #1;
    checks++;
    if (host_gnt !== 1'b1 || img_addr !== ha) begin
      errors++;
      $display("FAIL host_keeps_grant: got gnt=%b addr=%h expected gnt=1 addr=%h", host_gnt, img_addr, ha);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      checks++;
      if ({host_gnt, frame_busy, blur_start} !== 3'b100) begin
        errors++;
        $display("FAIL pending_hold: got gnt/busy/start=%b expected 100", {host_gnt, frame_busy, blur_start});
      end
    end
    @(negedge clk);
    host_req = 1'b0;
    #1;
    checks++;
    if (host_gnt !== 1'b0 || img_addr !== ba || frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL host_release: got gnt=%b addr=%h busy=%b expected gnt=0 addr=%h busy=0",
               host_gnt, img_addr, frame_busy, ba);
    end
    @(negedge clk);
    checks++;
    if ({blur_start, blur_sel, frame_busy} !== 4'b1001) begin
      errors++;
      $display("FAIL pending_start: got start/sel/busy=%b expected 1001", {blur_start, blur_sel, frame_busy});
    end
    host_req = 1'b1;
    #1;
    checks++;
    if (host_gnt !== 1'b0 || img_addr !== ba) begin
      errors++;
      $display("FAIL no_grant_busy: got gnt=%b addr=%h expected gnt=0 addr=%h", host_gnt, img_addr, ba);
    end
    @(negedge clk);
    blur_done = 1'b1;
    waited = 0;
    while (!frame_done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited !== GAP + 1) begin
      errors++;
      $display("FAIL pending_frame_done: got %0d cycles expected %0d", waited, GAP + 1);
    end
    @(negedge clk);
    blur_done = 1'b0;
    #1;
    checks++;
    if (host_gnt !== 1'b1 || frame_busy !== 1'b0) begin
      errors++;
      $display("FAIL regrant_after_frame: got gnt=%b busy=%b expected gnt=1 busy=0", host_gnt, frame_busy);
    end
    @(negedge clk);
    host_req = 1'b0;
    @(negedge clk);
    host_req = 1'b1; frame_start = 1'b1; num_scales = 3'd1;
    #1;
    checks++;
    if (host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL frame_wins: got gnt=%b expected 0", host_gnt);
    end
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if (blur_start !== 1'b1 || host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL frame_wins_start: got start=%b gnt=%b expected start=1 gnt=0", blur_start, host_gnt);
    end
    @(negedge clk);
    blur_done = 1'b1;
    waited = 0;
    while (!frame_done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited !== GAP + 1) begin
      errors++;
      $display("FAIL frame_wins_done: got %0d cycles expected %0d", waited, GAP + 1);
    end
    @(negedge clk);
    blur_done = 1'b0;
    host_req  = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_busy !== 1'b0 || host_gnt !== 1'b0) begin
      errors++;
      $display("FAIL host_idle_end: got busy=%b gnt=%b expected 0 0", frame_busy, host_gnt);
    end
  endtask

  task automatic test_reset_mid();
    int since, n_st, sel2;
    @(negedge clk);
    frame_start = 1'b1; num_scales = 3'd4;
    since = -1; n_st = 0; sel2 = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (blur_start) begin
        n_st++;
        since = 0;
        if (n_st == 2) sel2 = int'(blur_sel);
      end else if (since >= 0) begin
        since++;
      end
      blur_done = (since == 4);
      if (n_st == 2 && since == 3) break;
    end
    checks++;
    if (n_st !== 2 || sel2 !== 1) begin
      errors++;
      $display("FAIL reach_pass2: got starts=%0d sel=%0d expected starts=2 sel=1", n_st, sel2);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({frame_busy, frame_done, frame_err, blur_start, blur_sel, host_gnt} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b expected 000000",
               {frame_busy, frame_done, frame_err, blur_start, blur_sel, host_gnt});
    end
    checks++;
    if (img_addr !== blur_img_addr) begin
      errors++;
      $display("FAIL mid_reset_img_addr: got %h expected %h", img_addr, blur_img_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_frame("restart", 3'd1, 5, 0, 0, 0, 2, 1'b0);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; num_scales = '0; blur_done = 1'b0;
    blur_img_addr = '0; host_req = 1'b0; host_addr = '0;
    test_reset();
    test_full_frame();
    test_saturation();
    test_busy_ignore();
    test_done_level();
    test_timeout();
    test_host();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
